// File: rtl/donut_scanout.sv
// VGA timing generator and scanout engine for the donut frame buffer.
// Two-stage pipeline: counters/address -> sync/visibility + buffer data -> output registers.
module donut_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int FB_W        = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int COLOR_MODE  = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    output logic [14:0] addr_rd_o,
    input  logic [3:0]  data_i,
    output logic [11:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        vblank_o,
    output logic        frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
    } st1_t;

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          vis0;
    logic [14:0]   row;
    logic [14:0]   col;
    logic [14:0]   addr0;
    logic [11:0]   pal;
    st1_t          s1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hc <= '0;
            vc <= '0;
        end else if (cen_i) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
            end else begin
                hc <= hc + HW'(1);
            end
        end
    end

    assign vis0 = (hc < H_ACT) && (vc < V_ACT);
    assign col  = 15'(hc >> SCALE_SHIFT);
    assign row  = 15'(vc >> SCALE_SHIFT);

    // For the 160-wide buffer the stride multiply is two shifts and an add.
    generate
        if (FB_W == 160) begin : g_mul160
            assign addr0 = (row << 7) + (row << 5) + col;
        end else begin : g_mul
            assign addr0 = 15'(row * 15'(FB_W)) + col;
        end
    endgenerate

    assign addr_rd_o = vis0 ? addr0 : '0;

    // Sync flags reset to their inactive level so no stray pulse leaves stage 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= '{vis: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0, fs: 1'b0};
        end else if (cen_i) begin
            s1.vis <= vis0;
            s1.hs  <= !((hc >= HS_BEG) && (hc < HS_END));
            s1.vs  <= !((vc >= VS_BEG) && (vc < VS_END));
            s1.vb  <= (vc >= V_ACT);
            s1.fs  <= (hc == '0) && (vc == '0);
        end
    end

    assign pal = (COLOR_MODE == 1) ? {4'h0, data_i, 4'h0} : {data_i, data_i, data_i};

    // frame_start_o is dropped on any non-enabled edge so it stays one clk wide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o         <= '0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            de_o          <= 1'b0;
            vblank_o      <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (cen_i) begin
            rgb_o         <= s1.vis ? pal : 12'h000;
            hsync_o       <= s1.hs;
            vsync_o       <= s1.vs;
            de_o          <= s1.vis;
            vblank_o      <= s1.vb;
            frame_start_o <= s1.fs;
        end else begin
            frame_start_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_donut_scanout.sv
// Directed bench for donut_scanout on a narrow-line timing (12 px/line, 525 lines).
// A second instance in green palette shares all inputs and is cross-checked.
module tb_donut_scanout;
    localparam int HA = 8, HF = 1, HS = 2, HB = 1, HT = 12;
    localparam int VA = 480, VF = 10, VS = 2, VB = 33, VT = 525;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [14:0] addr, addr_g;
    logic [3:0]  data;
    logic [11:0] rgb, rgb_g;
    logic        hs, vs, de, vb, fs;
    logic        hs_g, vs_g, de_g, vb_g, fs_g;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Buffer model: ram[a] = a[3:0], read on the shared enable.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) data <= 4'h0;
        else if (cen) data <= addr[3:0];

    donut_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FB_W(160), .SCALE_SHIFT(2), .COLOR_MODE(0)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .addr_rd_o(addr), .data_i(data),
        .rgb_o(rgb), .hsync_o(hs), .vsync_o(vs), .de_o(de), .vblank_o(vb),
        .frame_start_o(fs)
    );

    donut_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FB_W(160), .SCALE_SHIFT(2), .COLOR_MODE(1)
    ) u_grn (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .addr_rd_o(addr_g), .data_i(4'hA),
        .rgb_o(rgb_g), .hsync_o(hs_g), .vsync_o(vs_g), .de_o(de_g), .vblank_o(vb_g),
        .frame_start_o(fs_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_addr(int idx);
        int h, v;
        h = idx % HT;
        v = (idx / HT) % VT;
        return (h < HA && v < VA) ? (v / 4) * 160 + h / 4 : 0;
    endfunction

    initial begin
        int   t, o, oh, ov, first, run;
        logic ovis, prev_hs, prev_vs;
        int   e_addr, e_de, e_rgb, e_hs, e_vs, e_vb, e_fs, e_grn, e_hper;
        int   n_de, n_hl, n_vl, n_vb, n_fs, n_hf, n_vf, last_hf, last_vf, vper;
        int   e_hold, e_hper2, e_hwid, n_hf2, n_fs2, last_hf2, last_vf2, vper2, lo_start;
        logic [11:0] p_rgb;
        logic        p_de, p_hs, p_vs, p_vb;

        // Reset state
        repeat (3) tick();
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hsync", 32'(hs), 1);
        chk("rst_vsync", 32'(vs), 1);
        chk("rst_de", 32'(de), 0);
        chk("rst_vblank", 32'(vb), 0);
        chk("rst_fs", 32'(fs), 0);
        chk("rst_addr", 32'(addr), 0);

        // First frame start: two ticks after release
        rst_n = 1'b1;
        tick();
        chk("t1_fs", 32'(fs), 0);
        chk("t1_de", 32'(de), 0);
        tick();
        chk("t2_fs", 32'(fs), 1);
        chk("t2_de", 32'(de), 1);
        chk("t2_rgb", 32'(rgb), 0);
        chk("t2_grn_rgb", 32'(rgb_g), 'h0A0);
        for (int p = 1; p < 8; p++) begin
            tick();
            chk("first_px_rgb", 32'(rgb), (p < 4) ? 0 : 'h111);
        end

        // Two full frames against the timing model, cen every clk
        t = 9;
        e_addr = 0; e_de = 0; e_rgb = 0; e_hs = 0; e_vs = 0; e_vb = 0; e_fs = 0;
        e_grn = 0; e_hper = 0;
        n_de = 0; n_hl = 0; n_vl = 0; n_vb = 0; n_fs = 0; n_hf = 0; n_vf = 0;
        last_hf = -1; last_vf = -1; vper = -1;
        prev_hs = hs; prev_vs = vs;
        for (int n = 0; n < 2 * FRAME; n++) begin
            tick();
            t++;
            o = t - 2;
            oh = o % HT;
            ov = (o / HT) % VT;
            ovis = (oh < HA) && (ov < VA);
            if (32'(addr) != m_addr(t)) e_addr++;
            if (de !== ovis) e_de++;
            if (32'(rgb) != (ovis ? (m_addr(o) % 16) * 'h111 : 0)) e_rgb++;
            if (hs !== !(oh >= HA + HF && oh < HA + HF + HS)) e_hs++;
            if (vs !== !(ov >= VA + VF && ov < VA + VF + VS)) e_vs++;
            if (vb !== (ov >= VA)) e_vb++;
            if (fs !== (oh == 0 && ov == 0)) e_fs++;
            if (32'(rgb_g) != (ovis ? 'h0A0 : 0) || de_g !== de || vb_g !== vb ||
                hs_g !== hs || vs_g !== vs || fs_g !== fs || addr_g !== addr) e_grn++;
            if (de) n_de++;
            if (!hs) n_hl++;
            if (!vs) n_vl++;
            if (vb) n_vb++;
            if (fs) n_fs++;
            if (prev_hs && !hs) begin
                if (last_hf >= 0 && t - last_hf != HT) e_hper++;
                last_hf = t;
                n_hf++;
            end
            if (prev_vs && !vs) begin
                if (last_vf >= 0) vper = t - last_vf;
                last_vf = t;
                n_vf++;
            end
            prev_hs = hs;
            prev_vs = vs;
            if (t == 479 * HT + 7)  chk("addr_last_px", 32'(addr), 119 * 160 + 1);
            if (t == 479 * HT + 8)  chk("addr_blank", 32'(addr), 0);
            if (t == 479 * HT + 9)  chk("de_last_px", 32'(de), 1);
            if (t == 479 * HT + 10) chk("de_fall", 32'(de), 0);
        end
        chk("model_addr", e_addr, 0);
        chk("model_de", e_de, 0);
        chk("model_rgb", e_rgb, 0);
        chk("model_hsync", e_hs, 0);
        chk("model_vsync", e_vs, 0);
        chk("model_vblank", e_vb, 0);
        chk("model_fs", e_fs, 0);
        chk("green_inst", e_grn, 0);
        chk("hsync_period", e_hper, 0);
        chk("hsync_falls", n_hf, 2 * VT);
        chk("hsync_low_cnt", n_hl, 2 * VT * HS);
        chk("vsync_falls", n_vf, 2);
        chk("vsync_period", vper, FRAME);
        chk("vsync_low_cnt", n_vl, 2 * VS * HT);
        chk("de_cnt", n_de, 2 * HA * VA);
        chk("vblank_cnt", n_vb, 2 * (VT - VA) * HT);
        chk("fs_cnt", n_fs, 2);

        // cen every other clk: periods double, outputs hold, frame start stays one clk
        cen = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        e_hold = 0; e_hper2 = 0; e_hwid = 0; n_hf2 = 0; n_fs2 = 0;
        last_hf2 = -1; last_vf2 = -1; vper2 = -1; lo_start = -1;
        p_rgb = rgb; p_de = de; p_hs = hs; p_vs = vs; p_vb = vb;
        for (int k = 0; k < 4 * FRAME; k++) begin
            cen = (k % 2 == 0);
            tick();
            if (!cen && (rgb !== p_rgb || de !== p_de || hs !== p_hs || vs !== p_vs ||
                         vb !== p_vb || fs !== 1'b0)) e_hold++;
            if (fs) n_fs2++;
            if (p_hs && !hs) begin
                if (last_hf2 >= 0 && k - last_hf2 != 2 * HT) e_hper2++;
                last_hf2 = k;
                lo_start = k;
                n_hf2++;
            end
            if (!p_hs && hs && lo_start >= 0 && k - lo_start != 2 * HS) e_hwid++;
            if (p_vs && !vs) begin
                if (last_vf2 >= 0) vper2 = k - last_vf2;
                last_vf2 = k;
            end
            p_rgb = rgb; p_de = de; p_hs = hs; p_vs = vs; p_vb = vb;
        end
        chk("half_cen_hold", e_hold, 0);
        chk("half_cen_hperiod", e_hper2, 0);
        chk("half_cen_hwidth", e_hwid, 0);
        chk("half_cen_hfalls", n_hf2, 2 * VT);
        chk("half_cen_vperiod", vper2, 2 * FRAME);
        chk("half_cen_fs_clks", n_fs2, 2);

        // Reset asserted mid-frame at line 200
        cen = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 200 * HT + 6; n++) tick();
        chk("pre_rst_de", 32'(de), 1);
        chk("pre_rst_rgb", 32'(rgb), 'h111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_de", 32'(de), 0);
        chk("async_rst_rgb", 32'(rgb), 0);
        chk("async_rst_hsync", 32'(hs), 1);
        chk("async_rst_vsync", 32'(vs), 1);
        chk("async_rst_vblank", 32'(vb), 0);
        chk("async_rst_fs", 32'(fs), 0);
        chk("async_rst_addr", 32'(addr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerst_t1_fs", 32'(fs), 0);
        tick();
        chk("rerst_t2_fs", 32'(fs), 1);
        first = -1;
        run = 0;
        for (int n = 1; n <= FRAME + 5; n++) begin
            tick();
            if (fs) begin
                run++;
                if (first < 0) first = n;
            end
        end
        chk("rerst_fs_period", first, FRAME);
        chk("rerst_fs_count", run, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
